// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter
//
// Two ATM terminals share one bank of NUM_ACCT 16-bit account balances.
// A three-state FSM (IDLE -> EXEC -> COMMIT) grants the store to one
// terminal at a time. Terminals are chosen round-robin. Each transaction
// takes a fixed two cycles from the grant edge to the done pulse.
//
// Optional feature macro: ATM_WD_LIMIT_EN
//   When defined, a withdrawal larger than WD_LIMIT is refused with status
//   LIMIT. When undefined, there is no limit check and WD_LIMIT is unused.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset (0 = reset)
//   req0/req1      transaction request from terminal 0/1
//   op0/op1        01 withdraw, 10 deposit, 11 balance, 00 illegal
//   acct0/acct1    account index
//   amt0/amt1      unsigned amount (ignored for balance)
//   gnt            one-hot, terminal currently owning the account store
//   done0/done1    one-cycle completion pulse per terminal
//   status         0 OK, 1 INSUF, 2 OVF, 3 BADACCT, 4 BADOP, 5 LIMIT
//   bal_out        account balance after the last committed transaction
//   busy           FSM is not IDLE
module atm_txn_arbiter #(
    parameter int          NUM_ACCT = 7,
    parameter logic [15:0] INIT_BAL = 16'd500,
    parameter logic [15:0] WD_LIMIT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [2:0]  acct0,
    input  logic [2:0]  acct1,
    input  logic [15:0] amt0,
    input  logic [15:0] amt1,
    output logic [1:0]  gnt,
    output logic        done0,
    output logic        done1,
    output logic [2:0]  status,
    output logic [15:0] bal_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, COMMIT} FsmState;

    typedef enum logic [2:0] {
        ST_OK      = 3'd0,
        ST_INSUF   = 3'd1,
        ST_OVF     = 3'd2,
        ST_BADACCT = 3'd3,
        ST_BADOP   = 3'd4,
        ST_LIMIT   = 3'd5
    } StatusCode;

    localparam logic [1:0] OP_ILLEGAL  = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_BALANCE  = 2'b11;

    FsmState     state;
    logic [15:0] balances [NUM_ACCT];
    logic [1:0]  capOp;
    logic [2:0]  capAcct;
    logic [15:0] capAmt;
    StatusCode   pendStatus;
    logic [15:0] pendBal;
    logic [1:0]  served;
    logic        rrPrio;

    logic        elig0;
    logic        elig1;
    logic        pick1;
    logic        badAcct;
    logic [15:0] curBal;
    logic [16:0] depSum;
    StatusCode   execStatus;
    logic [15:0] execBal;

    // A terminal that was just served stays ineligible until its req has
    // been seen low. Otherwise a held req would be served over and over.
    // rrPrio names the terminal that wins when both are eligible.
    assign elig0   = req0 & ~served[0];
    assign elig1   = req1 & ~served[1];
    assign pick1   = elig1 & (~elig0 | rrPrio);
    assign busy    = (state != IDLE);
    assign badAcct = (int'(capAcct) >= NUM_ACCT);

    // Compute the outcome of the captured transaction from the current
    // balance. The checks are ordered so that later assignments override
    // earlier ones: a bad account beats everything, and the withdrawal
    // limit (when compiled in) beats an insufficient balance.
    always_comb begin
        curBal     = '0;
        if (!badAcct) curBal = balances[capAcct];
        depSum     = {1'b0, curBal} + {1'b0, capAmt};
        execStatus = ST_OK;
        execBal    = curBal;
        if (badAcct) begin
            execStatus = ST_BADACCT;
            execBal    = '0;
        end else begin
            case (capOp)
                OP_WITHDRAW: begin
                    if (capAmt > curBal) execStatus = ST_INSUF;
                    else                 execBal    = curBal - capAmt;
`ifdef ATM_WD_LIMIT_EN
                    if (capAmt > WD_LIMIT) begin
                        execStatus = ST_LIMIT;
                        execBal    = curBal;
                    end
`endif
                end
                OP_DEPOSIT: begin
                    if (depSum[16]) execStatus = ST_OVF;
                    else            execBal    = depSum[15:0];
                end
                OP_BALANCE: begin
                    execStatus = ST_OK;
                end
                OP_ILLEGAL: begin
                    execStatus = ST_BADOP;
                end
                default: begin
                    execStatus = ST_BADOP;
                end
            endcase
        end
    end

`ifdef ATM_WD_LIMIT_EN
`else
    logic unusedWdLimit;
    assign unusedWdLimit = ^WD_LIMIT;
`endif

    // Main FSM. Requests are looked at only in IDLE, where the winner's
    // op/acct/amt are captured. EXEC registers the computed result. COMMIT
    // writes the balance back (only when the result is OK), publishes
    // status/bal_out, pulses done and marks the terminal as served.
    // Because the write happens on the edge that leaves COMMIT, a reset in
    // EXEC or COMMIT leaves the store untouched and produces no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            status     <= '0;
            bal_out    <= '0;
            served     <= '0;
            rrPrio     <= 1'b0;
            capOp      <= '0;
            capAcct    <= '0;
            capAmt     <= '0;
            pendStatus <= ST_OK;
            pendBal    <= '0;
            for (int i = 0; i < NUM_ACCT; i++) balances[i] <= INIT_BAL;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (!req0) served[0] <= 1'b0;
            if (!req1) served[1] <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        gnt     <= pick1 ? 2'b10 : 2'b01;
                        rrPrio  <= ~pick1;
                        capOp   <= pick1 ? op1 : op0;
                        capAcct <= pick1 ? acct1 : acct0;
                        capAmt  <= pick1 ? amt1 : amt0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    pendStatus <= execStatus;
                    pendBal    <= execBal;
                    state      <= COMMIT;
                end
                COMMIT: begin
                    if (pendStatus == ST_OK) balances[capAcct] <= pendBal;
                    status  <= pendStatus;
                    bal_out <= pendBal;
                    done0   <= gnt[0];
                    done1   <= gnt[1];
                    if (gnt[0]) served[0] <= 1'b1;
                    if (gnt[1]) served[1] <= 1'b1;
                    gnt     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// tb_atm_txn_arbiter
//
// Testbench for atm_txn_arbiter. It has three parts:
//   - a table of single-terminal transactions with fixed expected results
//   - hand-written sequences for round-robin, a late loser request and a
//     reset during EXEC
//   - a randomized phase checked every cycle against a transaction-level
//     model of the account store
// Optional feature macro: ATM_WD_LIMIT_EN (must match the DUT build).
module tb_atm_txn_arbiter;

    localparam int          NUM_ACCT = 7;
    localparam logic [15:0] INIT_BAL = 16'd500;
    localparam logic [15:0] WD_LIMIT = 16'd5000;
`ifdef ATM_WD_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [2:0]  acct0, acct1;
    logic [15:0] amt0, amt1;
    logic [1:0]  gnt;
    logic        done0, done1;
    logic [2:0]  status;
    logic [15:0] bal_out;
    logic        busy;

    int errors = 0;
    int checks = 0;

    atm_txn_arbiter #(
        .NUM_ACCT(NUM_ACCT),
        .INIT_BAL(INIT_BAL),
        .WD_LIMIT(WD_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .acct0(acct0), .acct1(acct1),
        .amt0(amt0), .amt1(amt1),
        .gnt(gnt), .done0(done0), .done1(done1),
        .status(status), .bal_out(bal_out), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        bit          term;
        logic [1:0]  op;
        logic [2:0]  acct;
        logic [15:0] amt;
        logic [2:0]  expStatus;
        logic [15:0] expBal;
        bit          chkBal;
    } vec_t;

    vec_t vecs[$];

    // Model of the account store and the expected outputs
    int          mBal [NUM_ACCT];
    bit          mServed [2];
    bit          mPrio;
    int          mPhase, mTerm, mAcct, mResStatus, mResBal;
    logic [1:0]  eGnt;
    logic        eDone0, eDone1, eBusy;
    logic [2:0]  eStatus;
    logic [15:0] eBalOut;
    bit          eBalValid;

    function automatic vec_t mkVec(bit term, logic [1:0] op, logic [2:0] acct,
                                   logic [15:0] amt, logic [2:0] st,
                                   logic [15:0] bal, bit chk);
        vec_t v;
        v.term = term; v.op = op; v.acct = acct; v.amt = amt;
        v.expStatus = st; v.expBal = bal; v.chkBal = chk;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        acct0 = 0; acct1 = 0; amt0 = 0; amt1 = 0;
    endtask

    task automatic applyStimulus(input bit term, input logic [1:0] op,
                                 input logic [2:0] acct, input logic [15:0] amt);
        if (!term) begin
            req0 = 1; op0 = op; acct0 = acct; amt0 = amt;
        end else begin
            req1 = 1; op1 = op; acct1 = acct; amt1 = amt;
        end
    endtask

    // Lower the request and scramble the fields, so that any late
    // sampling of the inputs would corrupt the result
    task automatic dropReq(input bit term);
        if (!term) begin
            req0 = 0; op0 = 2'($urandom); acct0 = 3'($urandom); amt0 = 16'($urandom);
        end else begin
            req1 = 0; op1 = 2'($urandom); acct1 = 3'($urandom); amt1 = 16'($urandom);
        end
    endtask

    task automatic doReset();
        rst = 0;
        idleInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(v.term, v.op, v.acct, v.amt);
        tick();
        checkOutput($sformatf("vec%0d.gnt", idx), gnt, v.term ? 2'b10 : 2'b01);
        dropReq(v.term);
        tick();
        checkOutput($sformatf("vec%0d.doneEarly", idx), v.term ? done1 : done0, 0);
        tick();
        checkOutput($sformatf("vec%0d.done", idx), v.term ? done1 : done0, 1);
        checkOutput($sformatf("vec%0d.otherDone", idx), v.term ? done0 : done1, 0);
        checkOutput($sformatf("vec%0d.status", idx), status, v.expStatus);
        if (v.chkBal) checkOutput($sformatf("vec%0d.bal", idx), bal_out, v.expBal);
        checkOutput($sformatf("vec%0d.busyIdle", idx), busy, 0);
        tick();
        checkOutput($sformatf("vec%0d.doneLate", idx), v.term ? done1 : done0, 0);
        checkOutput($sformatf("vec%0d.statusHold", idx), status, v.expStatus);
    endtask

    function automatic void evalTxn(input int op, input int acct, input int amt,
                                    output int st, output int b);
        if (acct >= NUM_ACCT) begin
            st = 3; b = 0;
        end else if (op == 0) begin
            st = 4; b = mBal[acct];
        end else if (op == 3) begin
            st = 0; b = mBal[acct];
        end else if (op == 2) begin
            if (mBal[acct] + amt > 65535) begin st = 2; b = mBal[acct]; end
            else begin st = 0; b = mBal[acct] + amt; end
        end else begin
            if (LIMIT_ON && amt > int'(WD_LIMIT)) begin st = 5; b = mBal[acct]; end
            else if (amt > mBal[acct]) begin st = 1; b = mBal[acct]; end
            else begin st = 0; b = mBal[acct] - amt; end
        end
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NUM_ACCT; i++) mBal[i] = int'(INIT_BAL);
        mServed[0] = 0; mServed[1] = 0; mPrio = 0; mPhase = 0;
        eGnt = 0; eDone0 = 0; eDone1 = 0; eBusy = 0;
        eStatus = 0; eBalOut = 0; eBalValid = 1;
    endtask

    // One clock edge of the model. mPhase counts the cycles left in the
    // current transaction: a grant costs two edges, and the result is
    // published on the second one.
    task automatic stepModel();
        bit r [2];
        bit justServed [2];
        bit e0, e1;
        int w, st, b;
        r[0] = req0; r[1] = req1;
        justServed[0] = 0; justServed[1] = 0;
        eDone0 = 0; eDone1 = 0;
        if (mPhase == 1) begin
            if (mResStatus == 0) mBal[mAcct] = mResBal;
            eStatus = 3'(mResStatus); eBalOut = 16'(mResBal);
            eBalValid = (mResStatus != 4);
            if (mTerm == 0) eDone0 = 1; else eDone1 = 1;
            justServed[mTerm] = 1;
            eGnt = 0; mPhase = 0;
        end else if (mPhase == 2) begin
            mPhase = 1;
        end else begin
            e0 = r[0] && !mServed[0];
            e1 = r[1] && !mServed[1];
            if (e0 || e1) begin
                w = (e0 && e1) ? int'(mPrio) : (e1 ? 1 : 0);
                mPrio = (w == 0);
                mTerm = w;
                if (w == 0) begin
                    evalTxn(int'(op0), int'(acct0), int'(amt0), st, b); mAcct = int'(acct0);
                end else begin
                    evalTxn(int'(op1), int'(acct1), int'(amt1), st, b); mAcct = int'(acct1);
                end
                mResStatus = st; mResBal = b;
                mPhase = 2;
                eGnt = (w == 1) ? 2'b10 : 2'b01;
            end
        end
        for (int t = 0; t < 2; t++) begin
            if (justServed[t]) mServed[t] = 1;
            else if (!r[t]) mServed[t] = 0;
        end
        eBusy = (mPhase != 0);
    endtask

    task automatic randTerm(output logic r, output logic [1:0] op,
                            output logic [2:0] acct, output logic [15:0] amt);
        int sel;
        r = ($urandom_range(0, 9) < 6);
        sel = $urandom_range(0, 9);
        op = (sel == 0) ? 2'b00 : (sel < 4) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
        acct = 3'($urandom_range(0, 7));
        sel = $urandom_range(0, 9);
        if (sel == 0) amt = 16'($urandom_range(60000, 65535));
        else if (sel == 1 && acct < NUM_ACCT) amt = 16'(mBal[acct]);
        else if (sel == 2 && acct < NUM_ACCT) amt = 16'(mBal[acct] + 1);
        else if (sel == 3) amt = 16'($urandom_range(4990, 6010));
        else amt = 16'($urandom_range(0, 800));
    endtask

    initial begin
        idleInputs();
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.gnt", gnt, 0);
        checkOutput("rst.done0", done0, 0);
        checkOutput("rst.done1", done1, 0);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.status", status, 0);
        checkOutput("rst.bal", bal_out, 0);
        @(negedge clk);
        rst = 1;
        tick();

        // Single-terminal transactions starting from a fresh store
        vecs.push_back(mkVec(0, 2'b11, 3'd2, 16'd0,     3'd0, 16'd500,  1));
        vecs.push_back(mkVec(0, 2'b10, 3'd2, 16'd400,   3'd0, 16'd900,  1));
        vecs.push_back(mkVec(0, 2'b01, 3'd2, 16'd300,   3'd0, 16'd600,  1));
        vecs.push_back(mkVec(0, 2'b11, 3'd2, 16'd0,     3'd0, 16'd600,  1));
        vecs.push_back(mkVec(1, 2'b01, 3'd1, 16'd501,   3'd1, 16'd500,  1));
        vecs.push_back(mkVec(1, 2'b11, 3'd1, 16'd0,     3'd0, 16'd500,  1));
        vecs.push_back(mkVec(1, 2'b01, 3'd1, 16'd500,   3'd0, 16'd0,    1));
        vecs.push_back(mkVec(0, 2'b10, 3'd1, 16'd1,     3'd0, 16'd1,    1));
        vecs.push_back(mkVec(1, 2'b10, 3'd1, 16'hFFFF,  3'd2, 16'd1,    1));
        vecs.push_back(mkVec(0, 2'b10, 3'd7, 16'd5,     3'd3, 16'd0,    1));
        vecs.push_back(mkVec(0, 2'b00, 3'd0, 16'd5,     3'd4, 16'd0,    0));
        vecs.push_back(mkVec(1, 2'b00, 3'd7, 16'd5,     3'd3, 16'd0,    1));
        vecs.push_back(mkVec(0, 2'b10, 3'd3, 16'd8500,  3'd0, 16'd9000, 1));
        vecs.push_back(mkVec(1, 2'b01, 3'd3, 16'd6000,  LIMIT_ON ? 3'd5 : 3'd0,
                             LIMIT_ON ? 16'd9000 : 16'd3000, 1));
        vecs.push_back(mkVec(0, 2'b11, 3'd3, 16'd0,     3'd0,
                             LIMIT_ON ? 16'd9000 : 16'd3000, 1));
        vecs.push_back(mkVec(1, 2'b10, 3'd6, 16'd0,     3'd0, 16'd500,  1));
        vecs.push_back(mkVec(0, 2'b01, 3'd5, 16'd0,     3'd0, 16'd500,  1));
        foreach (vecs[i]) runVector(vecs[i], i);

        // Both terminals request on the same edge and hold their requests
        doReset();
        applyStimulus(0, 2'b11, 3'd0, 16'd0);
        applyStimulus(1, 2'b11, 3'd1, 16'd0);
        tick(); checkOutput("rr.gnt0", gnt, 2'b01);
        checkOutput("rr.busy", busy, 1);
        tick(); checkOutput("rr.gntHold", gnt, 2'b01);
        tick(); checkOutput("rr.done0", done0, 1);
        checkOutput("rr.done1Low", done1, 0);
        checkOutput("rr.bal0", bal_out, 500);
        checkOutput("rr.gntClr", gnt, 0);
        tick(); checkOutput("rr.gnt1", gnt, 2'b10);
        tick();
        tick(); checkOutput("rr.done1", done1, 1);
        checkOutput("rr.bal1", bal_out, 500);
        tick(); checkOutput("rr.noReserve", gnt, 0);
        checkOutput("rr.notBusy", busy, 0);
        tick(); checkOutput("rr.stillIdle", gnt, 0);
        req0 = 0;
        tick(); checkOutput("rr.dropIdle", gnt, 0);
        applyStimulus(0, 2'b11, 3'd5, 16'd0);
        tick(); checkOutput("rr.regrant0", gnt, 2'b01);
        idleInputs();
        repeat (4) tick();

        // The loser raises its request while the store is in COMMIT
        doReset();
        applyStimulus(0, 2'b10, 3'd2, 16'd50);
        tick(); checkOutput("late.gnt0", gnt, 2'b01);
        dropReq(0);
        tick(); checkOutput("late.gntHold", gnt, 2'b01);
        applyStimulus(1, 2'b01, 3'd2, 16'd20);
        tick(); checkOutput("late.done0", done0, 1);
        checkOutput("late.bal0", bal_out, 550);
        checkOutput("late.noGrantInCommit", gnt, 0);
        tick(); checkOutput("late.gnt1", gnt, 2'b10);
        dropReq(1);
        tick();
        tick(); checkOutput("late.done1", done1, 1);
        checkOutput("late.bal1", bal_out, 530);
        checkOutput("late.status1", status, 0);
        tick();

        // Reset arrives while a deposit is in EXEC
        doReset();
        applyStimulus(0, 2'b10, 3'd4, 16'd100);
        tick(); checkOutput("abort.busy", busy, 1);
        #2 rst = 0;
        #1;
        checkOutput("abort.gnt", gnt, 0);
        checkOutput("abort.busyClr", busy, 0);
        checkOutput("abort.done0", done0, 0);
        applyStimulus(0, 2'b11, 3'd4, 16'd0);
        tick(); checkOutput("abort.noDone1", done0, 0);
        tick(); checkOutput("abort.noDone2", done0, 0);
        @(negedge clk);
        rst = 1;
        tick(); checkOutput("abort.firstGrant", gnt, 2'b01);
        dropReq(0);
        tick();
        tick(); checkOutput("abort.done", done0, 1);
        checkOutput("abort.balReinit", bal_out, 500);
        checkOutput("abort.status", status, 0);
        tick();

        // Randomized traffic against the model
        doReset();
        resetModel();
        for (int c = 0; c < 800; c++) begin
            randTerm(req0, op0, acct0, amt0);
            randTerm(req1, op1, acct1, amt1);
            @(posedge clk);
            stepModel();
            #1;
            checkOutput($sformatf("rnd%0d.gnt", c), gnt, eGnt);
            checkOutput($sformatf("rnd%0d.done0", c), done0, eDone0);
            checkOutput($sformatf("rnd%0d.done1", c), done1, eDone1);
            checkOutput($sformatf("rnd%0d.busy", c), busy, eBusy);
            checkOutput($sformatf("rnd%0d.status", c), status, eStatus);
            if (eBalValid) checkOutput($sformatf("rnd%0d.bal", c), bal_out, eBalOut);
        end
        idleInputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
